mem_bus_arbiter: RTL and testbench

Sequences a single shared single-port memory bus between the pipeline's instruction fetch (IF) and load/store (MEM) stages. Per pipeline advance, it services the data access first and the instruction fetch second, capturing each result in hold registers. While accesses are outstanding it freezes the pipeline (`StallPipe`) and bubbles the MEM/WB register (`FlushW`). Sits between the pipeline/hazard unit and the SoC memory interconnect.

---
 rtl/soc_bus_pkg.sv | 13 +
 rtl/bus_timeout_cnt.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the pipeline memory bus arbiter: FSM encoding and bus constants.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    INSTR   = 2'd2,
    RELEASE = 2'd3
  } bus_state_t;

  localparam logic [3:0] BUS_STRB_NONE = 4'b0000;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts cycles a bus access waits for BusReady; expired fires in the wait cycle that reaches TIMEOUT.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_cnt
      logic [TO_W-1:0] count;

      always_ff @(posedge clk) begin
        if (!rst) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end

      // The increment happening this cycle is the one that reaches TIMEOUT.
      assign expired = enable && (count == TO_W'(TIMEOUT - 1));
    end else begin : g_off
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst ^ clear ^ enable;
      assign expired     = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between MEM (data first) and IF (instruction second),
// stalling the pipeline and bubbling MEM/WB until both hold registers are filled.
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IfReq,
  input  logic [31:0] IfAddr,
  input  logic        MemReq,
  input  logic        MemWe,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWdata,
  input  logic [3:0]  MemWstrb,
  output logic [31:0] IfRdata,
  output logic [31:0] MemRdata,
  output logic        BusErr,
  output logic        StallPipe,
  output logic        FlushW,
  output logic        BusValid,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWdata,
  output logic [3:0]  BusWstrb,
  input  logic        BusReady,
  input  logic [31:0] BusRdata
);

  bus_state_t state, state_next;
  logic       busy;
  logic       to_clear;
  logic       to_enable;
  logic       to_expired;

  assign busy      = (state == DATA) || (state == INSTR);
  assign to_enable = busy && !BusReady;
  // Any completed access leaves DATA/INSTR, so the next access always starts from zero.
  assign to_clear  = !busy || BusReady;

  bus_timeout_cnt #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    StallPipe  = 1'b0;
    BusValid   = 1'b0;
    BusWe      = 1'b0;
    BusAddr    = '0;
    BusWdata   = '0;
    BusWstrb   = BUS_STRB_NONE;
    case (state)
      IDLE: begin
        StallPipe = IfReq | MemReq;
        if (MemReq) begin
          state_next = DATA;
        end else if (IfReq) begin
          state_next = INSTR;
        end
      end
      DATA: begin
        StallPipe = 1'b1;
        BusValid  = 1'b1;
        BusWe     = MemWe;
        BusAddr   = MemAddr;
        BusWdata  = MemWdata;
        BusWstrb  = MemWe ? MemWstrb : BUS_STRB_NONE;
        if (BusReady) begin
          state_next = IfReq ? INSTR : RELEASE;
        end else if (to_expired) begin
          state_next = RELEASE;
        end
      end
      INSTR: begin
        StallPipe = 1'b1;
        BusValid  = 1'b1;
        BusAddr   = IfAddr;
        if (BusReady || to_expired) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign FlushW = StallPipe;

  // A timed-out access zeroes its target register so the pipeline never sees stale data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      IfRdata  <= '0;
      MemRdata <= '0;
      BusErr   <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_next != IDLE)) begin
        BusErr <= 1'b0;
      end
      if (state == DATA) begin
        if (BusReady) begin
          if (!MemWe) begin
            MemRdata <= BusRdata;
          end
        end else if (to_expired) begin
          MemRdata <= '0;
          BusErr   <= 1'b1;
        end
      end
      if (state == INSTR) begin
        if (BusReady) begin
          IfRdata <= BusRdata;
        end else if (to_expired) begin
          IfRdata <= '0;
          BusErr  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-advance sequences against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        IfReq, MemReq, MemWe, BusReady;
  logic [31:0] IfAddr, MemAddr, MemWdata, BusRdata;
  logic [3:0]  MemWstrb;
  logic [31:0] IfRdata, MemRdata, BusAddr, BusWdata;
  logic        BusErr, StallPipe, FlushW, BusValid, BusWe;
  logic [3:0]  BusWstrb;

  int total = 0;
  int bad   = 0;

  logic [31:0] if_m, mem_m;
  logic        err_m;

  mem_bus_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .IfReq(IfReq), .IfAddr(IfAddr), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWdata(MemWdata), .MemWstrb(MemWstrb), .IfRdata(IfRdata),
    .MemRdata(MemRdata), .BusErr(BusErr), .StallPipe(StallPipe), .FlushW(FlushW),
    .BusValid(BusValid), .BusWe(BusWe), .BusAddr(BusAddr), .BusWdata(BusWdata),
    .BusWstrb(BusWstrb), .BusReady(BusReady), .BusRdata(BusRdata)
  );

  always #5 clk = ~clk;

  // One pipeline advance: IDLE, optional data access, optional fetch, RELEASE.
  // A wait count >= TO means the slave never answers within the timeout.
  task automatic do_seq(input bit mreq, input bit we, input logic [31:0] maddr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input bit ireq, input logic [31:0] iaddr,
                        input int dwait, input int iwait,
                        input logic [31:0] drd, input logic [31:0] ird,
                        output int stall_seen, output int valid_seen);
    bit timed_out;
    int n;
    stall_seen = 0;
    valid_seen = 0;
    timed_out  = 0;
    @(negedge clk);
    IfReq = ireq; IfAddr = iaddr; MemReq = mreq; MemWe = we; MemAddr = maddr;
    MemWdata = wdata; MemWstrb = strb; BusReady = 1'($urandom); BusRdata = $urandom;
    #1;
    stall_seen += int'(StallPipe);
    valid_seen += int'(BusValid);
    total++;
    if ({BusValid, StallPipe, FlushW, BusErr} !== {1'b0, ireq | mreq, ireq | mreq, err_m}) begin
      bad++;
      $display("[TB] FAIL idle_ctrl got=%b want=%b", {BusValid, StallPipe, FlushW, BusErr},
               {1'b0, ireq | mreq, ireq | mreq, err_m});
    end
    @(posedge clk);
    if (!(ireq || mreq)) return;
    err_m = 1'b0;
    if (mreq) begin
      n = (dwait >= TO) ? TO : dwait + 1;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        BusReady = (c == dwait);
        BusRdata = (c == dwait) ? drd : $urandom;
        #1;
        stall_seen += int'(StallPipe);
        valid_seen += int'(BusValid);
        total++;
        if ({BusValid, BusWe, StallPipe, FlushW, BusErr, BusWstrb, BusAddr, IfRdata, MemRdata} !==
            {1'b1, we, 1'b1, 1'b1, 1'b0, we ? strb : 4'b0000, maddr, if_m, mem_m}) begin
          bad++;
          $display("[TB] FAIL data_cycle%0d got=%b_%h_%h_%h want=%b_%h_%h_%h", c,
                   {BusValid, BusWe, StallPipe, FlushW, BusErr, BusWstrb}, BusAddr, IfRdata, MemRdata,
                   {1'b1, we, 3'b110, we ? strb : 4'b0000}, maddr, if_m, mem_m);
        end
        if (we) begin
          total++;
          if (BusWdata !== wdata) begin
            bad++;
            $display("[TB] FAIL store_wdata got=%h want=%h", BusWdata, wdata);
          end
        end
        @(posedge clk);
      end
      if (dwait >= TO) begin
        timed_out = 1;
        mem_m     = '0;
        err_m     = 1'b1;
      end else if (!we) begin
        mem_m = drd;
      end
    end
    if (ireq && !timed_out) begin
      n = (iwait >= TO) ? TO : iwait + 1;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        BusReady = (c == iwait);
        BusRdata = (c == iwait) ? ird : $urandom;
        MemReq   = 1'($urandom);
        #1;
        stall_seen += int'(StallPipe);
        valid_seen += int'(BusValid);
        total++;
        if ({BusValid, BusWe, StallPipe, FlushW, BusErr, BusWstrb, BusAddr, IfRdata, MemRdata} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, iaddr, if_m, mem_m}) begin
          bad++;
          $display("[TB] FAIL instr_cycle%0d got=%b_%h_%h_%h want=%b_%h_%h_%h", c,
                   {BusValid, BusWe, StallPipe, FlushW, BusErr, BusWstrb}, BusAddr, IfRdata, MemRdata,
                   9'b101100000, iaddr, if_m, mem_m);
        end
        @(posedge clk);
      end
      if (iwait >= TO) begin
        if_m  = '0;
        err_m = 1'b1;
      end else begin
        if_m = ird;
      end
    end
    @(negedge clk);
    BusReady = 1'($urandom);
    BusRdata = $urandom;
    IfReq    = 1'($urandom);
    MemReq   = 1'($urandom);
    #1;
    stall_seen += int'(StallPipe);
    valid_seen += int'(BusValid);
    total++;
    if ({BusValid, StallPipe, FlushW, BusErr, IfRdata, MemRdata} !==
        {1'b0, 1'b0, 1'b0, err_m, if_m, mem_m}) begin
      bad++;
      $display("[TB] FAIL release got=%b_%h_%h want=%b_%h_%h", {BusValid, StallPipe, FlushW, BusErr},
               IfRdata, MemRdata, {3'b000, err_m}, if_m, mem_m);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    IfReq = 1'b1; MemReq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    IfReq = 1'($urandom); MemReq = 1'($urandom);
    #1;
    total++;
    if ({BusValid, StallPipe, BusErr, IfRdata, MemRdata} !== {1'b0, IfReq | MemReq, 1'b0, 64'd0}) begin
      bad++;
      $display("[TB] FAIL reset got=%b_%h_%h", {BusValid, StallPipe, BusErr}, IfRdata, MemRdata);
    end
    IfReq = 1'b0; MemReq = 1'b0; rst = 1'b1;
    if_m = '0; mem_m = '0; err_m = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_idle();
    int s, v;
    for (int i = 0; i < 3; i++) begin
      do_seq(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, s, v);
    end
  endtask

  task automatic test_fetch();
    int s, v;
    do_seq(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0050_0093, s, v);
    total++;
    if (s !== 2 || v !== 1) begin
      bad++;
      $display("[TB] FAIL fetch_cycles stall=%0d valid=%0d want stall=2 valid=1", s, v);
    end
  endtask

  task automatic test_load_fetch();
    int s, v;
    do_seq(1, 0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0000_0014, 2, 2,
           32'hDEAD_BEEF, 32'h0000_0013, s, v);
    total++;
    if (s + 1 !== 8 || v !== 6) begin
      bad++;
      $display("[TB] FAIL load_fetch_cycles total=%0d valid=%0d want total=8 valid=6", s + 1, v);
    end
  endtask

  task automatic test_store();
    int s, v;
    do_seq(1, 1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 0, 32'h0, 3, 0,
           32'hFFFF_FFFF, 32'h0, s, v);
  endtask

  task automatic test_timeout();
    int s, v;
    do_seq(1, 0, 32'h0000_0300, 32'h0, 4'h0, 1, 32'h0000_0018, 20, 0,
           32'h0, 32'h0, s, v);
    total++;
    if (s !== 5) begin
      bad++;
      $display("[TB] FAIL timeout_cycles stall=%0d want=5", s);
    end
    do_seq(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0000_001C, 1, 0, 32'h0, 32'h0000_0033, s, v);
  endtask

  task automatic test_reset_mid();
    int s, v;
    do_seq(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0000_0020, 0, 0, 32'h0, 32'hCAFE_0001, s, v);
    @(negedge clk);
    IfReq = 1'b1; MemReq = 1'b1; MemWe = 1'b0; MemAddr = 32'h0000_0400; BusReady = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      BusReady = 1'b0;
      if (c == 1) rst = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    IfReq = 1'($urandom); MemReq = 1'($urandom);
    #1;
    total++;
    if ({BusValid, StallPipe, BusErr, IfRdata, MemRdata} !== {1'b0, IfReq | MemReq, 1'b0, 64'd0}) begin
      bad++;
      $display("[TB] FAIL reset_mid got=%b_%h_%h", {BusValid, StallPipe, BusErr}, IfRdata, MemRdata);
    end
    IfReq = 1'b0; MemReq = 1'b0; rst = 1'b1;
    if_m = '0; mem_m = '0; err_m = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_random();
    int s, v, dw, iw;
    for (int i = 0; i < 25; i++) begin
      dw = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
      iw = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
      do_seq(1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom), $urandom,
             dw, iw, $urandom, $urandom, s, v);
    end
  endtask

  initial begin
    rst = 1'b0; IfReq = 1'b0; MemReq = 1'b0; MemWe = 1'b0; BusReady = 1'b0;
    IfAddr = '0; MemAddr = '0; MemWdata = '0; MemWstrb = '0; BusRdata = '0;
    if_m = '0; mem_m = '0; err_m = 1'b0;
    test_reset();
    test_idle();
    test_fetch();
    test_load_fetch();
    test_store();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
